// File: rtl/net_axis_pkg.sv
// Shared AXI-Stream beat type and arbiter state encoding for the network egress path.
package net_axis_pkg;

   localparam int NET_DATA_W = 64;
   localparam int NET_KEEP_W = NET_DATA_W / 8;

   typedef struct packed {
      logic [NET_DATA_W-1:0] data;
      logic [NET_KEEP_W-1:0] keep;
      logic                  last;
   } axis_beat_t;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   // Round-robin successor of an index, wrapping back to 0 at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer for one AXI-Stream beat. The output side is driven
// straight from registers, and in_ready depends only on local state, so the
// slice breaks every combinational path between its two sides.
module axis_reg_slice
   import net_axis_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  axis_beat_t in_beat,
   input  logic       in_valid,
   output logic       in_ready,
   output axis_beat_t out_beat,
   output logic       out_valid,
   input  logic       out_ready
);

   axis_beat_t skid_beat;
   logic       skid_valid;
   logic       push;

   // The skid entry is only occupied while the output entry is too, so an
   // occupied skid entry means the slice is full.
   assign in_ready = !skid_valid;
   assign push     = in_valid && in_ready;

   // Refill the output entry from the skid entry first (oldest beat), otherwise
   // from the input; park the input beat in the skid entry while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_beat   <= '0;
         out_valid  <= 1'b0;
         skid_beat  <= '0;
         skid_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_beat   <= skid_beat;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (push) begin
            out_beat  <= in_beat;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (push) begin
         skid_beat  <= in_beat;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/net_tx_arbiter.sv
// Packet-granular round-robin arbiter onto the single toNet AXI-Stream egress.
// A grant is held from the first beat of a packet through its tlast beat; the
// egress is fully registered through axis_reg_slice. A watchdog raises a sticky
// stall_err when the granted source goes quiet mid-packet, without revoking the grant.
module net_tx_arbiter
   import net_axis_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int DATA_W    = NET_DATA_W,
   parameter int STALL_MAX = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_SRC*DATA_W-1:0]     src_tdata,
   input  logic [N_SRC*DATA_W/8-1:0]   src_tkeep,
   input  logic [N_SRC-1:0]            src_tvalid,
   input  logic [N_SRC-1:0]            src_tlast,
   output logic [N_SRC-1:0]            src_tready,
   output logic [DATA_W-1:0]           toNet_tdata,
   output logic [DATA_W/8-1:0]         toNet_tkeep,
   output logic                        toNet_tvalid,
   output logic                        toNet_tlast,
   input  logic                        toNet_tready,
   output logic [$clog2(N_SRC)-1:0]    grant_id,
   output logic                        busy,
   output logic                        stall_err
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int IDX_W  = $clog2(N_SRC);
   localparam int WD_W   = $clog2(STALL_MAX) + 1;

   arb_state_e       state;
   arb_state_e       state_nxt;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand;
   logic             pick_found;
   logic             sel_valid;
   logic             slice_in_ready;
   logic             accept;
   axis_beat_t       slice_in;
   axis_beat_t       slice_out;
   logic             slice_out_valid;
   logic [WD_W-1:0]  wd_cnt;

   // Rotating-priority search: first valid source at or after rr_ptr.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_SRC);
         if (!pick_found && src_tvalid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign sel_valid = (state == XFER) && src_tvalid[grant_id];
   assign accept    = sel_valid && slice_in_ready;
   assign slice_in  = '{data: src_tdata[int'(grant_id)*DATA_W +: DATA_W],
                        keep: src_tkeep[int'(grant_id)*KEEP_W +: KEEP_W],
                        last: src_tlast[grant_id]};

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: grant when anyone requests, release on the accepted tlast beat.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = XFER;
         XFER:    if (accept && slice_in.last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: only the granted source sees ready, gated by slice room.
   always_comb begin
      src_tready = '0;
      busy       = (state == XFER);
      if (state == XFER) src_tready[grant_id] = slice_in_ready;
   end

   // Latch the winner on arbitration; advance the pointer past it at end of packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         if (state == IDLE && pick_found) grant_id <= pick_idx;
         if (accept && slice_in.last) rr_ptr <= IDX_W'(rr_next(int'(grant_id), N_SRC));
      end
   end

   // Stall watchdog: count quiet cycles of the granted source, saturating at STALL_MAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt    <= '0;
         stall_err <= 1'b0;
      end else begin
         if (state != XFER || accept) wd_cnt <= '0;
         else if (!src_tvalid[grant_id] && wd_cnt != WD_W'(STALL_MAX)) wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_cnt == WD_W'(STALL_MAX)) stall_err <= 1'b1;
      end
   end

   axis_reg_slice u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_beat   (slice_in),
      .in_valid  (sel_valid),
      .in_ready  (slice_in_ready),
      .out_beat  (slice_out),
      .out_valid (slice_out_valid),
      .out_ready (toNet_tready)
   );

   assign toNet_tdata  = slice_out.data;
   assign toNet_tkeep  = slice_out.keep;
   assign toNet_tlast  = slice_out.last;
   assign toNet_tvalid = slice_out_valid;

endmodule
